// File: rtl/bus_arbiter_pkg.sv
// Shared types for the bus arbiter: cycle widths, arbiter states and requester ids.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    CW_BYTE = 2'd0,
    CW_WORD = 2'd1,
    CW_LONG = 2'd2
  } t_cycle_width;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DATA  = 3'd2,
    EXT   = 3'd3,
    TURN  = 3'd4
  } t_arb_state;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_FETCH = 2'd1,
    REQ_DATA  = 2'd2,
    REQ_EXT   = 2'd3
  } t_requester;

  localparam int WD_WIDTH = 8;

  // Starvation counter width: wide enough for the limit, never below 3 bits.
  function automatic int starve_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus cycle watchdog: counts wait-state cycles and flags expiry at TIMEOUT.
module bus_watchdog
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WD_WIDTH-1:0] count;

  assign expired = (count == WD_WIDTH'(TIMEOUT));

  // Holds at the expiry value so the flag stays stable until the next clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + WD_WIDTH'(1);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the external bus between fetch, memory-stage data and an external master.
// Valid/ready: a requester holds req and operands until its ack pulse; the slave ends a cycle with bus_ready.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic         reset,
  input  logic         clock,
  input  logic         fetch_req,
  input  logic [31:0]  fetch_address,
  output logic         fetch_ack,
  input  logic         data_req,
  input  logic         data_write,
  input  logic [31:0]  data_address,
  input  t_cycle_width data_width,
  input  logic [31:0]  data_write_data,
  output logic         data_ack,
  input  logic         ext_req,
  output logic         ext_grant,
  output logic [31:0]  bus_address,
  output logic [31:0]  bus_data_out,
  output t_cycle_width bus_cycle_width,
  output logic         bus_read,
  output logic         bus_write,
  input  logic         bus_ready,
  output logic         fetch_stall,
  output logic         timeout_error,
  output t_arb_state   debug_state
);

  localparam int SW = starve_width(STARVE_LIMIT);

  t_arb_state      state, next_state;
  t_requester      winner;
  logic [SW-1:0]   starve_count;
  logic            in_cycle, cycle_done, expired;
  logic            grant_fetch, grant_data;

  assign in_cycle    = (state == FETCH) || (state == DATA);
  assign cycle_done  = in_cycle && (bus_ready || expired);
  assign grant_fetch = (state == IDLE) && (winner == REQ_FETCH);
  assign grant_data  = (state == IDLE) && (winner == REQ_DATA);
  assign debug_state = state;

  // Priority select: external master, then a starved fetch, then data, then fetch.
  always_comb begin
    winner = REQ_NONE;
    if (ext_req) begin
      winner = REQ_EXT;
    end else if (fetch_req && (starve_count == SW'(STARVE_LIMIT))) begin
      winner = REQ_FETCH;
    end else if (data_req) begin
      winner = REQ_DATA;
    end else if (fetch_req) begin
      winner = REQ_FETCH;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        case (winner)
          REQ_EXT:   next_state = EXT;
          REQ_FETCH: next_state = FETCH;
          REQ_DATA:  next_state = DATA;
          default:   next_state = IDLE;
        endcase
      end
      FETCH, DATA: if (cycle_done) next_state = TURN;
      EXT:         if (!ext_req) next_state = TURN;
      TURN:        next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  always_comb begin
    fetch_ack     = (state == FETCH) && cycle_done;
    data_ack      = (state == DATA) && cycle_done;
    timeout_error = cycle_done && !bus_ready;
    ext_grant     = (state == EXT);
    fetch_stall   = fetch_req && !fetch_ack;
  end

  // Bus outputs are loaded at the grant edge, held through wait states and
  // cleared at the edge that ends the cycle, so TURN and EXT see a quiet bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_address     <= '0;
      bus_data_out    <= '0;
      bus_cycle_width <= CW_LONG;
      bus_read        <= 1'b0;
      bus_write       <= 1'b0;
    end else if (grant_fetch) begin
      bus_address     <= fetch_address;
      bus_data_out    <= '0;
      bus_cycle_width <= CW_LONG;
      bus_read        <= 1'b1;
      bus_write       <= 1'b0;
    end else if (grant_data) begin
      bus_address     <= data_address;
      bus_data_out    <= data_write ? data_write_data : 32'h0;
      bus_cycle_width <= data_width;
      bus_read        <= !data_write;
      bus_write       <= data_write;
    end else if ((next_state != FETCH) && (next_state != DATA)) begin
      bus_address     <= '0;
      bus_data_out    <= '0;
      bus_cycle_width <= CW_LONG;
      bus_read        <= 1'b0;
      bus_write       <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_count <= '0;
    end else if (grant_fetch) begin
      starve_count <= '0;
    end else if (data_ack && fetch_req && (starve_count != SW'(STARVE_LIMIT))) begin
      starve_count <= starve_count + SW'(1);
    end
  end

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (grant_fetch || grant_data),
    .enable  (in_cycle && !bus_ready),
    .expired (expired)
  );

endmodule
